// File: rtl/tftlcd_timing_recover.sv
// tftlcd_timing_recover
//   Sink-side timing recovery for a parallel RGB (hsync/vsync/DE) stream.
//   Registers the incoming stream, recovers pixel coordinates and frame
//   markers, measures the active geometry and reports lock when the stream
//   matches the expected resolution for LOCK_FRAMES consecutive frames.
//
// Ports:
//   in_clk, in_rst_n          pixel clock, asynchronous active-low reset
//   in_hsync, in_vsync        line / frame sync, active low
//   in_en, in_data            data enable and pixel data
//   out_valid, out_data       delayed pixel (2-cycle latency)
//   out_pixelx, out_pixely    0-based coordinates of the delayed pixel
//   out_sof, out_eol          first pixel of frame / last pixel of line
//   out_hlen, out_vlen        measured line width / frame height
//   out_locked, out_err       geometry lock and 1-cycle error pulse
module tftlcd_timing_recover #(
  parameter int H_PIXEL_LENGTH = 480,
  parameter int V_PIXEL_LENGTH = 272,
  parameter int PIXELX_WIDTH   = 9,
  parameter int PIXELY_WIDTH   = 9,
  parameter int DATA_WIDTH     = 24,
  parameter int LOCK_FRAMES    = 2,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                    in_clk,
  input  logic                    in_rst_n,
  input  logic                    in_hsync,
  input  logic                    in_vsync,
  input  logic                    in_en,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic                    out_valid,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [PIXELX_WIDTH:0]   out_pixelx,
  output logic [PIXELY_WIDTH:0]   out_pixely,
  output logic                    out_sof,
  output logic                    out_eol,
  output logic [PIXELX_WIDTH:0]   out_hlen,
  output logic [PIXELY_WIDTH:0]   out_vlen,
  output logic                    out_locked,
  output logic                    out_err
);

  localparam int XW = PIXELX_WIDTH + 1;
  localparam int YW = PIXELY_WIDTH + 1;
  localparam int MW = $clog2(LOCK_FRAMES + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {ST_UNLOCKED, ST_SEEK, ST_LOCKED} state_t;

  // Input pipeline: stage 1 samples the pins, stage 2 is the edge-detect copy.
  logic                  r_hs1, r_vs1, r_en1, r_vs2, r_en2;
  logic [DATA_WIDTH-1:0] r_d1, r_d2;
  // Stage-2 history is only trustworthy once a real sample has reached it;
  // this keeps a line or vsync in progress at reset release from looking
  // like a fresh edge.
  logic                  r_s1_real, r_s2_real;

  logic                  r_in_line;
  logic [XW-1:0]         r_x;
  logic [YW-1:0]         r_y;
  logic                  r_frame_bad;
  logic [WW-1:0]         r_wd;
  state_t                r_state, w_state_next;
  logic [MW-1:0]         r_match, w_match_next;
  logic                  w_err_next;

  logic                  w_rise, w_fall, w_vfall, w_pix, w_hs_bad;
  logic                  w_line_bad, w_frame_good, w_timeout;
  logic [XW-1:0]         w_hlen_new;
  logic [YW-1:0]         w_y_eff;

  assign w_rise   = r_s2_real & r_en1 & ~r_en2;
  // Falling edge is seen one cycle early (stage 1 low, stage 2 high), so it
  // coincides with the last pixel of the line sitting in stage 2.
  assign w_fall   = r_in_line & r_en2 & ~r_en1;
  assign w_vfall  = r_s2_real & r_vs2 & ~r_vs1;
  assign w_pix    = r_in_line & r_en2;
  assign w_hs_bad = w_rise & ~r_hs1;

  assign w_hlen_new = (r_x == '1) ? r_x : r_x + XW'(1);
  // Line ending in the same cycle as vsync falls is counted into this frame.
  assign w_y_eff    = (w_fall && (r_y != '1)) ? r_y + YW'(1) : r_y;
  assign w_line_bad = w_fall && (w_hlen_new != XW'(H_PIXEL_LENGTH));
  assign w_frame_good = ~r_frame_bad & ~w_line_bad & (w_y_eff == YW'(V_PIXEL_LENGTH));
  assign w_timeout  = ~w_vfall & (r_wd == WW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_state_next = r_state;
    w_match_next = r_match;
    w_err_next   = 1'b0;
    case (r_state)
      ST_UNLOCKED: begin
        if (w_vfall) begin
          w_state_next = ST_SEEK;
          w_match_next = '0;
        end
      end
      ST_SEEK: begin
        if (w_vfall) begin
          if (w_frame_good) begin
            w_match_next = r_match + MW'(1);
            if (int'(w_match_next) >= LOCK_FRAMES) w_state_next = ST_LOCKED;
          end else begin
            w_match_next = '0;
          end
        end
      end
      ST_LOCKED: begin
        if (w_line_bad || (w_vfall && !w_frame_good)) begin
          w_state_next = ST_UNLOCKED;
          w_match_next = '0;
          w_err_next   = 1'b1;
        end
      end
      default: w_state_next = ST_UNLOCKED;
    endcase
    if (w_timeout) begin
      w_state_next = ST_UNLOCKED;
      w_match_next = '0;
      w_err_next   = (r_state == ST_LOCKED);
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_hs1       <= 1'b1;
      r_vs1       <= 1'b1;
      r_en1       <= 1'b0;
      r_vs2       <= 1'b1;
      r_en2       <= 1'b0;
      r_d1        <= '0;
      r_d2        <= '0;
      r_s1_real   <= 1'b0;
      r_s2_real   <= 1'b0;
      r_in_line   <= 1'b0;
      r_x         <= '0;
      r_y         <= '0;
      r_frame_bad <= 1'b0;
      r_wd        <= '0;
      r_state     <= ST_UNLOCKED;
      r_match     <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_pixelx  <= '0;
      out_pixely  <= '0;
      out_sof     <= 1'b0;
      out_eol     <= 1'b0;
      out_hlen    <= '0;
      out_vlen    <= '0;
      out_locked  <= 1'b0;
      out_err     <= 1'b0;
    end else begin
      r_hs1     <= in_hsync;
      r_vs1     <= in_vsync;
      r_en1     <= in_en;
      r_d1      <= in_data;
      r_vs2     <= r_vs1;
      r_en2     <= r_en1;
      r_d2      <= r_d1;
      r_s1_real <= 1'b1;
      r_s2_real <= r_s1_real;

      if (w_rise)      r_in_line <= 1'b1;
      else if (w_fall) r_in_line <= 1'b0;

      if (w_rise)                   r_x <= '0;
      else if (w_pix && r_x != '1)  r_x <= r_x + XW'(1);

      if (w_vfall)                  r_y <= '0;
      else if (w_fall && r_y != '1) r_y <= r_y + YW'(1);

      // A sync violation on the first line of a new frame belongs to that frame.
      if (w_vfall) r_frame_bad <= w_hs_bad;
      else         r_frame_bad <= r_frame_bad | w_hs_bad | w_line_bad;

      if (w_vfall)                                r_wd <= '0;
      else if (r_wd != WW'(TIMEOUT_CYCLES))       r_wd <= r_wd + WW'(1);

      r_state <= w_state_next;
      r_match <= w_match_next;

      out_valid  <= w_pix;
      out_data   <= r_d2;
      out_pixelx <= r_x;
      out_pixely <= r_y;
      out_sof    <= w_pix & (r_x == '0) & (r_y == '0);
      out_eol    <= w_pix & ~r_en1;
      if (w_fall) out_hlen <= w_hlen_new;
      if (w_vfall && w_y_eff != '0) out_vlen <= w_y_eff;
      out_locked <= (w_state_next == ST_LOCKED);
      out_err    <= w_err_next;
    end
  end

endmodule

// File: tb/tb_tftlcd_timing_recover.sv
module tb_tftlcd_timing_recover;
  localparam int H  = 20;
  localparam int V  = 6;
  localparam int LF = 2;
  localparam int TO = 1000;
  localparam int M_UNL = 0, M_SEEK = 1, M_LOCK = 2;

  logic        in_clk = 1'b0;
  logic        in_rst_n = 1'b0;
  logic        in_hsync = 1'b1;
  logic        in_vsync = 1'b1;
  logic        in_en = 1'b0;
  logic [23:0] in_data = '0;
  logic        out_valid, out_sof, out_eol, out_locked, out_err;
  logic [23:0] out_data;
  logic [9:0]  out_pixelx, out_pixely, out_hlen, out_vlen;

  tftlcd_timing_recover #(
    .H_PIXEL_LENGTH(H), .V_PIXEL_LENGTH(V), .PIXELX_WIDTH(9), .PIXELY_WIDTH(9),
    .DATA_WIDTH(24), .LOCK_FRAMES(LF), .TIMEOUT_CYCLES(TO)
  ) dut (
    .in_clk(in_clk), .in_rst_n(in_rst_n), .in_hsync(in_hsync), .in_vsync(in_vsync),
    .in_en(in_en), .in_data(in_data), .out_valid(out_valid), .out_data(out_data),
    .out_pixelx(out_pixelx), .out_pixely(out_pixely), .out_sof(out_sof),
    .out_eol(out_eol), .out_hlen(out_hlen), .out_vlen(out_vlen),
    .out_locked(out_locked), .out_err(out_err)
  );

  always #5 in_clk = ~in_clk;

  int cyc = 0;
  always @(posedge in_clk) cyc <= cyc + 1;

  typedef struct {
    logic [23:0] d;
    int x;
    int y;
    bit sof;
    bit eol;
    int t;
  } exp_t;
  exp_t q[$];

  int n_cmp = 0, n_bad = 0;
  int err_seen = 0, err_last = 0, last_edge = 0, t_vfall = 0;

  // Reference model of the stream as the bench generates it.
  int m_state = M_UNL, m_match = 0, m_y = 0, m_hlen = 0, m_vlen = 0, m_err = 0;
  bit m_good = 1'b1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every out_valid pixel must match the oldest expected one.
  always @(negedge in_clk) begin
    exp_t e;
    if (in_rst_n) begin
      if (out_err) begin
        err_seen++;
        err_last = cyc;
      end
      if (out_valid) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL pixel: unexpected out_valid at cycle %0d x=%0d y=%0d", cyc, out_pixelx, out_pixely);
        end else begin
          e = q.pop_front();
          if (out_data !== e.d || int'(out_pixelx) != e.x || int'(out_pixely) != e.y ||
              out_sof !== e.sof || out_eol !== e.eol || cyc != e.t) begin
            n_bad++;
            $display("FAIL pixel: got cyc=%0d d=%h x=%0d y=%0d sof=%0b eol=%0b, expected cyc=%0d d=%h x=%0d y=%0d sof=%0b eol=%0b",
                     cyc, out_data, out_pixelx, out_pixely, out_sof, out_eol,
                     e.t, e.d, e.x, e.y, e.sof, e.eol);
          end
        end
      end else if (q.size() > 0 && q[0].t < cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL pixel_missing: got no out_valid, expected pixel x=%0d y=%0d at cycle %0d", q[0].x, q[0].y, q[0].t);
        void'(q.pop_front());
      end
    end
  end

  task automatic tick(input logic hs, input logic vs, input logic en, input logic [23:0] d);
    @(negedge in_clk);
    in_hsync = hs;
    in_vsync = vs;
    in_en    = en;
    in_data  = d;
    last_edge = cyc + 1;
  endtask

  task automatic model_line(input int len, input bit hsbad);
    m_hlen = len;
    if (len != H || hsbad) m_good = 1'b0;
    if (m_state == M_LOCK && len != H) begin
      m_state = M_UNL;
      m_match = 0;
      m_err++;
    end
    m_y++;
  endtask

  task automatic model_vfall();
    bit good;
    good = m_good && (m_y == V);
    if (m_y > 0) m_vlen = m_y;
    case (m_state)
      M_UNL: begin m_state = M_SEEK; m_match = 0; end
      M_SEEK: begin
        if (good) begin
          m_match++;
          if (m_match >= LF) m_state = M_LOCK;
        end else m_match = 0;
      end
      default: if (!good) begin m_state = M_UNL; m_match = 0; m_err++; end
    endcase
    m_y = 0;
    m_good = 1'b1;
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_locked"}, int'(out_locked), int'(m_state == M_LOCK));
    chk({tag, "_hlen"}, int'(out_hlen), m_hlen);
    chk({tag, "_vlen"}, int'(out_vlen), m_vlen);
    chk({tag, "_errcount"}, err_seen, m_err);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b1, 1'b0, 24'h0);
  endtask

  task automatic send_line(input int len, input bit hsbad, input logic [23:0] first_d, input bit use_first);
    logic [23:0] d;
    for (int i = 0; i < int'($urandom_range(1, 2)); i++) tick(1'b0, 1'b1, 1'b0, 24'h0);
    idle($urandom_range(1, 3));
    for (int i = 0; i < len; i++) begin
      exp_t e;
      d = (use_first && i == 0) ? first_d : 24'($urandom);
      tick((hsbad && i == 0) ? 1'b0 : 1'b1, 1'b1, 1'b1, d);
      e.d = d; e.x = i; e.y = m_y; e.sof = (i == 0 && m_y == 0);
      e.eol = (i == len - 1); e.t = last_edge + 2;
      q.push_back(e);
    end
    idle($urandom_range(1, 3));
    model_line(len, hsbad);
  endtask

  task automatic vsync_pulse(input string tag);
    tick(1'b1, 1'b0, 1'b0, 24'h0);
    t_vfall = last_edge;
    tick(1'b1, 1'b0, 1'b0, 24'h0);
    tick(1'b1, 1'b0, 1'b0, 24'h0);
    model_vfall();
    idle(4);
    check_status(tag);
  endtask

  // kind: 0 good, 1 one wrong-length line, 2 one line short, 3 hsync violation, 4 one line extra
  task automatic send_frame(input int kind, input string tag);
    int nl, bad_idx, blen;
    vsync_pulse(tag);
    for (int i = 0; i < int'($urandom_range(0, 1)); i++) begin
      tick(1'b0, 1'b1, 1'b0, 24'h0);
      idle(H + 4);
    end
    nl = (kind == 2) ? V - 1 : (kind == 4) ? V + 1 : V;
    bad_idx = $urandom_range(0, V - 2);
    for (int i = 0; i < nl; i++) begin
      blen = (kind == 1 && i == bad_idx) ? (($urandom_range(0, 1) == 0) ? H - 1 : H + 1) : H;
      send_line(blen, kind == 3 && i == bad_idx, 24'h0, 1'b0);
    end
  endtask

  initial begin
    int d, eb;
    // Reset state
    repeat (3) @(negedge in_clk);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_locked", int'(out_locked), 0);
    chk("rst_err", int'(out_err), 0);
    chk("rst_hlen", int'(out_hlen), 0);
    chk("rst_vlen", int'(out_vlen), 0);
    chk("rst_sof_eol", int'({out_sof, out_eol}), 0);
    in_rst_n = 1'b1;
    idle(4);

    // Single pixel before any vsync
    send_line(1, 1'b0, 24'hABCDEF, 1'b1);
    idle(3);
    check_status("single");

    // Ideal stream: lock after the second frame closes
    for (int f = 0; f < 3; f++) send_frame(0, "ideal");
    vsync_pulse("ideal_close");

    // One short line while locked, then relock
    send_frame(0, "pre_short");
    send_line(H - 1, 1'b0, 24'h0, 1'b0);
    idle(3);
    check_status("short_line");
    for (int f = 0; f < 3; f++) send_frame(0, "relock");

    // Missing line and hsync violation frames
    send_frame(2, "v_short");
    send_frame(0, "after_vshort");
    send_frame(3, "hs_bad");
    send_frame(0, "after_hsbad");

    // Randomized mix, mostly good frames
    for (int f = 0; f < 10; f++) begin
      int k;
      k = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
      send_frame(k, "random");
    end

    // Watchdog timeout while locked
    for (int f = 0; f < 4; f++) send_frame(0, "pre_timeout");
    vsync_pulse("timeout_start");
    eb = err_seen;
    idle(TO + 20);
    if (m_state == M_LOCK) m_err++;
    m_state = M_UNL;
    m_match = 0;
    chk("timeout_err_pulses", err_seen - eb, 1);
    d = err_last - t_vfall;
    chk("timeout_err_window", int'(d >= TO - 1 && d <= TO + 2), 1);
    check_status("timeout");

    // Asynchronous reset in the middle of a line
    send_frame(0, "pre_reset");
    tick(1'b0, 1'b1, 1'b0, 24'h0);
    idle(2);
    for (int i = 0; i < 10; i++) begin
      exp_t e;
      tick(1'b1, 1'b1, 1'b1, 24'($urandom));
      e.d = in_data; e.x = i; e.y = m_y; e.sof = (i == 0 && m_y == 0);
      e.eol = 1'b0; e.t = last_edge + 2;
      q.push_back(e);
    end
    @(negedge in_clk);
    in_rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_pixelx", int'(out_pixelx), 0);
    chk("mid_rst_locked", int'(out_locked), 0);
    chk("mid_rst_hlen", int'(out_hlen), 0);
    q.delete();
    m_state = M_UNL; m_match = 0; m_y = 0; m_hlen = 0; m_vlen = 0; m_good = 1'b1;
    tick(1'b1, 1'b1, 1'b1, 24'h1);
    tick(1'b1, 1'b1, 1'b1, 24'h2);
    @(negedge in_clk);
    in_rst_n = 1'b1;
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b1, 1'b1, 24'($urandom));
    idle(3);
    check_status("partial_line");
    send_line(H, 1'b0, 24'h0, 1'b0);
    idle(2);
    check_status("post_reset_line");
    for (int f = 0; f < 3; f++) send_frame(0, "post_reset");
    vsync_pulse("final");
    idle(5);
    chk("queue_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $finish;
  end
endmodule
